// File: rtl/sram_rw0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw0_ctrl
// Purpose  : Initiator-side controller for the read/write port 0 of a
//            32x512 dual-port SRAM macro. Converts a valid/ready request
//            stream into registered SRAM pin activity and returns read data
//            in order through a credit-protected response FIFO.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_we/req_wmask/req_addr/req_wdata - request
//            resp_valid/resp_ready/resp_rdata                       - response
//            init_done                                    - accepting traffic
//            sram_csb0/web0/wmask0/addr0/din0 (out), sram_dout0 (in) - macro
// Options  : SRAM_CLEAR_EN - when defined, a sweep FSM writes zero to every
//            word after reset release before traffic is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rw0_ctrl #(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int c_CW = $clog2(RESP_DEPTH) + 1;   // credit / count width
    localparam int c_PW = $clog2(RESP_DEPTH);       // FIFO pointer width

    logic                  r_init_done;
    logic                  w_init_nxt;
    logic                  w_clearing;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    logic                  w_accept;
    logic                  w_rd_acc;
    logic                  w_pop;
    logic                  r_rd_s1;
    logic                  r_rd_s2;
    logic [c_CW-1:0]       r_credit;

    logic [DATA_WIDTH-1:0] r_fifo [RESP_DEPTH];
    logic [c_PW-1:0]       r_wptr;
    logic [c_PW-1:0]       r_rptr;
    logic [c_CW-1:0]       r_count;

`ifdef SRAM_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clearing  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing = 1'b1;
                if (r_clr_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    assign w_clr_addr = r_clr_addr;
    // Registered one cycle behind the FSM so init_done rises the cycle after
    // the final sweep write is on the pins.
    assign w_init_nxt = (r_state == ST_READY);
`else
    assign w_clearing = 1'b0;
    assign w_clr_addr = '0;
    assign w_init_nxt = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= w_init_nxt;
        end
    end

    assign init_done = r_init_done;

    // Credit covers every read between acceptance and pop, so the FIFO can
    // never be asked to hold more than RESP_DEPTH entries. Writes are gated
    // too so that ready never depends on req_we.
    assign req_ready = r_init_done && (r_credit < c_CW'(RESP_DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_rd_acc  = w_accept && !req_we;
    assign w_pop     = resp_valid && resp_ready;

    // SRAM pins: sweep writes take priority (ready is low during the sweep).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (w_clearing) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= 1'b0;
            sram_wmask0 <= '1;
            sram_addr0  <= w_clr_addr;
            sram_din0   <= '0;
        end else if (w_accept) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= !req_we;
            sram_wmask0 <= req_we ? req_wmask : '0;
            sram_addr0  <= req_addr;
            sram_din0   <= req_wdata;
        end else begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
        end
    end

    // Read tag pipe: s1 marks a read on the pins, s2 marks the cycle the
    // macro drives dout0; dout0 is captured at the end of s2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_s1 <= 1'b0;
            r_rd_s2 <= 1'b0;
        end else begin
            r_rd_s1 <= w_rd_acc;
            r_rd_s2 <= r_rd_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= '0;
        end else begin
            case ({w_rd_acc, w_pop})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Response FIFO. Entries are cleared on reset so resp_rdata reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (r_rd_s2) begin
                r_fifo[r_wptr] <= sram_dout0;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({r_rd_s2, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign resp_valid = (r_count != '0);
    assign resp_rdata = r_fifo[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_sram_rw0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rw0_ctrl
// Purpose  : Self-checking bench for sram_rw0_ctrl with a behavioural SRAM
//            macro, a byte-masked reference memory and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_rw0_ctrl;

    localparam int c_NM    = 4;
    localparam int c_DW    = 32;
    localparam int c_AW    = 9;
    localparam int c_DEPTH = 1 << c_AW;
    localparam int c_RD    = 4;
`ifdef SRAM_CLEAR_EN
    localparam int c_INIT_EDGES = c_DEPTH + 1;
`else
    localparam int c_INIT_EDGES = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [c_NM-1:0] req_wmask = '0;
    logic [c_AW-1:0] req_addr = '0;
    logic [c_DW-1:0] req_wdata = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [c_DW-1:0] resp_rdata;
    logic            init_done;
    logic            sram_csb0;
    logic            sram_web0;
    logic [c_NM-1:0] sram_wmask0;
    logic [c_AW-1:0] sram_addr0;
    logic [c_DW-1:0] sram_din0;
    logic [c_DW-1:0] sram_dout0 = '0;

    always #5 clk = ~clk;

    sram_rw0_ctrl #(
        .NUM_WMASKS(c_NM), .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW),
        .RAM_DEPTH(c_DEPTH), .RESP_DEPTH(c_RD)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // Behavioural macro: pins sampled at the edge, read data driven after it.
    logic [c_DW-1:0] macro_mem [c_DEPTH];
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < c_NM; b++) begin
                    if (sram_wmask0[b]) macro_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
                end
            end else begin
                sram_dout0 <= macro_mem[sram_addr0];
            end
        end
    end

    // Reference memory and scoreboard.
    logic [c_DW-1:0] ref_mem [c_DEPTH];
    logic [c_DW-1:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_pop = 0;
    int outstanding = 0;
    int max_out = 0;
    int cyc = 0;
    bit chk_ready = 1'b0;
    bit rnd_rr = 1'b0;

    initial begin
        for (int i = 0; i < c_DEPTH; i++) begin
            macro_mem[i] = $urandom;
`ifdef SRAM_CLEAR_EN
            ref_mem[i] = '0;
`else
            ref_mem[i] = macro_mem[i];
`endif
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: decides acceptance/pop at the negedge, where all DUT outputs
    // and bench-driven inputs are stable for the upcoming edge.
    always @(negedge clk) begin
        if (!rst) begin
            bit acc, rd, pop;
            if (chk_ready) chk_eq("req_ready", req_ready, outstanding < c_RD);
            acc = req_valid && req_ready;
            rd  = acc && !req_we;
            pop = resp_valid && resp_ready;
            if (acc) begin
                n_acc++;
                if (req_we) begin
                    for (int b = 0; b < c_NM; b++)
                        if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
            if (resp_valid && !resp_ready && exp_q.size() > 0)
                chk_eq("rdata_hold", resp_rdata, exp_q[0]);
            if (pop) begin
                n_pop++;
                if (exp_q.size() == 0) chk_eq("spurious_resp", 1, 0);
                else chk_eq("rdata", resp_rdata, exp_q.pop_front());
            end
            outstanding = outstanding + int'(rd) - int'(pop);
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    // Random backpressure on the response side.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request is taken.
    task automatic do_req(input bit we, input logic [c_NM-1:0] m,
                          input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_wdata = d;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (req_ready) break;
            if (t > 2000) begin
                chk_eq("req_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    initial begin
        int a0, p0, c0;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_req_ready", req_ready, 0);
        chk_eq("rst_resp_valid", resp_valid, 0);
        chk_eq("rst_resp_rdata", resp_rdata, 0);
        chk_eq("rst_csb0", sram_csb0, 1);
        chk_eq("rst_web0", sram_web0, 1);
        chk_eq("rst_wmask0", sram_wmask0, 0);
        chk_eq("rst_addr0", sram_addr0, 0);
        chk_eq("rst_din0", sram_din0, 0);
        chk_eq("rst_init_done", init_done, 0);

`ifdef SRAM_CLEAR_EN
        // Interrupt the sweep partway, then confirm it restarts from zero.
        rst = 1'b0;
        repeat (201) @(posedge clk);
        #2;
        chk_eq("sweep_addr_200", sram_addr0, 200);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("sweep_rst_csb0", sram_csb0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk_eq("sweep_restart_addr", sram_addr0, 0);
        chk_eq("sweep_restart_csb0", sram_csb0, 0);
        repeat (c_INIT_EDGES - 2) @(posedge clk);
        #2;
        chk_eq("init_done_early", init_done, 0);
        @(posedge clk);
        #2;
        chk_eq("init_done_rise", init_done, 1);
`else
        rst = 1'b0;
        #1;
        chk_eq("init_done_early", init_done, 0);
        @(posedge clk);
        #2;
        chk_eq("init_done_rise", init_done, 1);
`endif
        @(negedge clk);
        chk_eq("idle_csb0", sram_csb0, 1);
        chk_eq("idle_web0", sram_web0, 1);
        chk_eq("idle_resp_valid", resp_valid, 0);
        chk_ready = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Masked writes then read, with latency check
        do_req(1'b1, 4'hF, 9'd5, 32'hDEADBEEF);
        do_req(1'b1, 4'h1, 9'd5, 32'h00000011);
        do_req(1'b0, 4'h0, 9'd5, 32'h0);
        idle();
        @(negedge clk);
        chk_eq("lat_n1", resp_valid, 0);
        @(negedge clk);
        chk_eq("lat_n2", resp_valid, 0);
        @(negedge clk);
        chk_eq("lat_n3", resp_valid, 1);
        chk_eq("rmw_rdata", resp_rdata, 32'hDEADBE11);
        @(posedge clk);
        #1;

        // Zero-mask write changes nothing
        do_req(1'b1, 4'h0, 9'd5, 32'h12345678);
        do_req(1'b0, 4'h0, 9'd5, 32'h0);
        idle();
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back streaming reads
        p0 = n_pop;
        c0 = cyc;
        for (int a = 0; a < 16; a++) do_req(1'b0, 4'h0, c_AW'(a), 32'h0);
        chk_eq("stream_cycles", cyc - c0, 16);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk_eq("stream_pops", n_pop - p0, 16);

        // Backpressure: exactly RESP_DEPTH reads accepted
        resp_ready = 1'b0;
        a0 = n_acc;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'd7;
        repeat (12) @(posedge clk);
        #1;
        idle();
        chk_eq("bp_accepts", n_acc - a0, c_RD);
        p0 = n_pop;
        resp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk_eq("bp_pops", n_pop - p0, c_RD);
        chk_eq("bp_outstanding", outstanding, 0);

        // Random mixed traffic with random backpressure
        rnd_rr = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
            do_req(1'($urandom_range(0, 1)), 4'($urandom), 9'($urandom_range(0, 15)), $urandom);
        end
        idle();
        rnd_rr = 1'b0;
        resp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk_eq("drain_queue_empty", exp_q.size(), 0);
        chk_eq("drain_outstanding", outstanding, 0);
        chk_eq("credit_max_ok", max_out <= c_RD, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
